// File: rtl/arp_rx_cache_pkg.sv
// Shared constants, header layout and state encoding for the ARP receiver.
package arp_pkg;

  localparam logic [15:0] HTYPE_ETH        = 16'h0001;
  localparam logic [15:0] PTYPE_IPV4       = 16'h0800;
  localparam logic [15:0] ARP_REQUEST_CODE = 16'd1;
  localparam logic [15:0] ARP_REPLY_CODE   = 16'd2;
  localparam logic [7:0]  HLEN_ETH         = 8'd6;
  localparam logic [7:0]  PLEN_IPV4        = 8'd4;

  // Byte offsets of each field inside the ARP payload
  localparam logic [7:0] OFF_HTYPE   = 8'd0;
  localparam logic [7:0] OFF_PTYPE   = 8'd2;
  localparam logic [7:0] OFF_HLEN    = 8'd4;
  localparam logic [7:0] OFF_PLEN    = 8'd5;
  localparam logic [7:0] OFF_OPER    = 8'd6;
  localparam logic [7:0] OFF_SHA     = 8'd8;
  localparam logic [7:0] OFF_SPA     = 8'd14;
  localparam logic [7:0] OFF_THA     = 8'd18;
  localparam logic [7:0] OFF_TPA     = 8'd24;
  localparam logic [7:0] ARP_HDR_LEN = 8'd28;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_RECV   = 3'd1;
  localparam logic [2:0] ST_CHECK  = 3'd2;
  localparam logic [2:0] ST_UPDATE = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;

  typedef struct packed {
    logic [15:0] htype;
    logic [15:0] ptype;
    logic [7:0]  hlen;
    logic [7:0]  plen;
    logic [15:0] oper;
    logic [47:0] sha;
    logic [31:0] spa;
    logic [47:0] tha;
    logic [31:0] tpa;
  } arp_hdr_t;

  // True when byte counter cnt falls inside the field [off, off+len)
  function automatic logic in_field(input logic [7:0] cnt, input logic [7:0] off,
                                    input logic [7:0] len);
    return (cnt >= off) && (cnt < off + len);
  endfunction

endpackage

// File: rtl/arp_cache.sv
// IP-to-MAC cache: entry storage, aging, refresh/insert with round-robin
// replacement, combinational SPA match and a registered lookup port.
module arp_cache
  import arp_pkg::*;
#(
  parameter int CACHE_DEPTH = 4,
  parameter int AGE_W = 8,
  parameter logic [AGE_W-1:0] MAX_AGE = 8'd200
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           age_tick,
  input  logic [31:0]                    match_ip,
  output logic                           match_hit,
  output logic [$clog2(CACHE_DEPTH)-1:0] match_idx,
  input  logic                           refresh_en,
  input  logic [$clog2(CACHE_DEPTH)-1:0] refresh_idx,
  input  logic                           insert_en,
  input  logic [31:0]                    wr_ip,
  input  logic [47:0]                    wr_mac,
  input  logic                           lookup_req,
  input  logic [31:0]                    lookup_ip,
  output logic                           lookup_ack,
  output logic                           lookup_hit,
  output logic [47:0]                    lookup_mac
);
  localparam int IDX_W = $clog2(CACHE_DEPTH);

  logic [CACHE_DEPTH-1:0] valid_reg;
  logic [31:0]            ip_mem  [CACHE_DEPTH];
  logic [47:0]            mac_mem [CACHE_DEPTH];
  logic [AGE_W-1:0]       age_reg [CACHE_DEPTH];
  logic [IDX_W-1:0]       rr_ptr_reg;

  logic [CACHE_DEPTH-1:0] match_vec;
  logic [CACHE_DEPTH-1:0] lookup_vec;
  logic                   lk_hit;
  logic [IDX_W-1:0]       lk_idx;
  logic                   free_any;
  logic [IDX_W-1:0]       free_idx;
  logic                   wr_en;
  logic [IDX_W-1:0]       wr_idx;

  generate
    for (genvar gi = 0; gi < CACHE_DEPTH; gi++) begin : g_cmp
      assign match_vec[gi]  = valid_reg[gi] && (ip_mem[gi] == match_ip);
      assign lookup_vec[gi] = valid_reg[gi] && (ip_mem[gi] == lookup_ip);
    end
  endgenerate

  // Lowest-index priority encoders for SPA match, lookup match and free slot
  always_comb begin
    match_hit = |match_vec;
    match_idx = '0;
    lk_hit    = |lookup_vec;
    lk_idx    = '0;
    free_any  = ~&valid_reg;
    free_idx  = '0;
    for (int i = CACHE_DEPTH - 1; i >= 0; i--) begin
      if (match_vec[i])  match_idx = IDX_W'(i);
      if (lookup_vec[i]) lk_idx    = IDX_W'(i);
      if (!valid_reg[i]) free_idx  = IDX_W'(i);
    end
  end

  // A refresh targets the matched entry; an insert prefers a free slot
  assign wr_en  = refresh_en || insert_en;
  assign wr_idx = refresh_en ? refresh_idx : (free_any ? free_idx : rr_ptr_reg);

  // Address/MAC storage; contents only matter while the entry is valid
  always_ff @(posedge clk) begin
    if (wr_en) begin
      ip_mem[wr_idx]  <= wr_ip;
      mac_mem[wr_idx] <= wr_mac;
    end
  end

  // Valid bits and age counters; a write overrides a coincident age tick
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_reg <= '0;
      for (int i = 0; i < CACHE_DEPTH; i++) age_reg[i] <= '0;
    end else begin
      for (int i = 0; i < CACHE_DEPTH; i++) begin
        if (wr_en && (wr_idx == IDX_W'(i))) begin
          valid_reg[i] <= 1'b1;
          age_reg[i]   <= MAX_AGE;
        end else if (age_tick && valid_reg[i]) begin
          age_reg[i] <= age_reg[i] - AGE_W'(1);
          if (age_reg[i] == AGE_W'(1)) valid_reg[i] <= 1'b0;
        end
      end
    end
  end

  // Round-robin victim pointer advances only when a full cache is overwritten
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_reg <= '0;
    end else if (insert_en && !refresh_en && !free_any) begin
      rr_ptr_reg <= (rr_ptr_reg == IDX_W'(CACHE_DEPTH - 1)) ? '0 : rr_ptr_reg + IDX_W'(1);
    end
  end

  // Registered lookup answer; reads contents as they were before any same-cycle write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lookup_ack <= 1'b0;
      lookup_hit <= 1'b0;
      lookup_mac <= '0;
    end else begin
      lookup_ack <= lookup_req;
      lookup_hit <= lookup_req && lk_hit;
      lookup_mac <= (lookup_req && lk_hit) ? mac_mem[lk_idx] : '0;
    end
  end

endmodule

// File: rtl/arp_rx_cache.sv
// ARP receiver: byte parser, header validation FSM, reply request and
// found logic, feeding a learning IP-to-MAC cache.
module arp_rx_cache
  import arp_pkg::*;
#(
  parameter int CACHE_DEPTH = 4,
  parameter int AGE_W = 8,
  parameter logic [AGE_W-1:0] MAX_AGE = 8'd200
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] local_ip_addr,
  input  logic [47:0] local_mac_addr,
  input  logic        arp_rx_req,
  input  logic        arp_rx_valid,
  input  logic [7:0]  arp_rx_data,
  input  logic        arp_rx_last,
  output logic        arp_rx_end,
  output logic        arp_reply_req,
  input  logic        arp_reply_ack,
  output logic [31:0] arp_reply_ip,
  output logic [47:0] arp_reply_mac,
  output logic        arp_found,
  input  logic        age_tick,
  input  logic        lookup_req,
  input  logic [31:0] lookup_ip,
  output logic        lookup_ack,
  output logic        lookup_hit,
  output logic [47:0] lookup_mac
);
  localparam int IDX_W = $clog2(CACHE_DEPTH);

  logic [2:0]       state_reg;
  logic [7:0]       cnt_reg;
  arp_hdr_t         hdr_reg;
  logic             frame_ok_reg;
  logic             hit_reg;
  logic [IDX_W-1:0] hit_idx_reg;

  logic             tpa_match;
  logic             tha_match;
  logic             frame_ok;
  logic             spa_hit;
  logic [IDX_W-1:0] spa_idx;
  logic             in_update;
  logic             refresh_en;
  logic             insert_en;
  logic             reply_set;
  logic             found_set;

  assign tpa_match = (hdr_reg.tpa == local_ip_addr);
  assign tha_match = (hdr_reg.tha == local_mac_addr);
  assign frame_ok  = (hdr_reg.htype == HTYPE_ETH) && (hdr_reg.ptype == PTYPE_IPV4) &&
                     (hdr_reg.hlen == HLEN_ETH) && (hdr_reg.plen == PLEN_IPV4) &&
                     ((hdr_reg.oper == ARP_REQUEST_CODE) || (hdr_reg.oper == ARP_REPLY_CODE)) &&
                     (hdr_reg.spa != 32'd0) && !hdr_reg.sha[40];

  assign in_update  = (state_reg == ST_UPDATE);
  assign refresh_en = in_update && frame_ok_reg && hit_reg;
  assign insert_en  = in_update && frame_ok_reg && !hit_reg && tpa_match;
  assign reply_set  = in_update && frame_ok_reg && (hdr_reg.oper == ARP_REQUEST_CODE) && tpa_match;
  assign found_set  = in_update && frame_ok_reg && (hdr_reg.oper == ARP_REPLY_CODE) &&
                      tpa_match && tha_match;

  // Frame FSM with byte counter; rx_end/found are single-cycle pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_IDLE;
      cnt_reg      <= '0;
      frame_ok_reg <= 1'b0;
      hit_reg      <= 1'b0;
      hit_idx_reg  <= '0;
      arp_rx_end   <= 1'b0;
      arp_found    <= 1'b0;
    end else begin
      arp_rx_end <= 1'b0;
      arp_found  <= found_set;
      case (state_reg)
        ST_IDLE: begin
          if (arp_rx_req) begin
            state_reg <= ST_RECV;
            cnt_reg   <= '0;
          end
        end
        ST_RECV: begin
          if (arp_rx_valid) begin
            if (cnt_reg != 8'hFF) cnt_reg <= cnt_reg + 8'd1;
            if (arp_rx_last) begin
              // Short frames skip validation and the cache entirely
              if (cnt_reg < ARP_HDR_LEN - 8'd1) begin
                state_reg  <= ST_DONE;
                arp_rx_end <= 1'b1;
              end else begin
                state_reg <= ST_CHECK;
              end
            end
          end
        end
        ST_CHECK: begin
          frame_ok_reg <= frame_ok;
          hit_reg      <= spa_hit;
          hit_idx_reg  <= spa_idx;
          state_reg    <= ST_UPDATE;
        end
        ST_UPDATE: begin
          state_reg  <= ST_DONE;
          arp_rx_end <= 1'b1;
        end
        ST_DONE:  state_reg <= ST_IDLE;
        default:  state_reg <= ST_IDLE;
      endcase
    end
  end

  // Shift each payload byte into the header field its offset belongs to
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hdr_reg <= '0;
    end else if ((state_reg == ST_RECV) && arp_rx_valid) begin
      if (in_field(cnt_reg, OFF_HTYPE, 8'd2)) hdr_reg.htype <= {hdr_reg.htype[7:0], arp_rx_data};
      if (in_field(cnt_reg, OFF_PTYPE, 8'd2)) hdr_reg.ptype <= {hdr_reg.ptype[7:0], arp_rx_data};
      if (cnt_reg == OFF_HLEN)                hdr_reg.hlen  <= arp_rx_data;
      if (cnt_reg == OFF_PLEN)                hdr_reg.plen  <= arp_rx_data;
      if (in_field(cnt_reg, OFF_OPER, 8'd2))  hdr_reg.oper  <= {hdr_reg.oper[7:0], arp_rx_data};
      if (in_field(cnt_reg, OFF_SHA, 8'd6))   hdr_reg.sha   <= {hdr_reg.sha[39:0], arp_rx_data};
      if (in_field(cnt_reg, OFF_SPA, 8'd4))   hdr_reg.spa   <= {hdr_reg.spa[23:0], arp_rx_data};
      if (in_field(cnt_reg, OFF_THA, 8'd6))   hdr_reg.tha   <= {hdr_reg.tha[39:0], arp_rx_data};
      if (in_field(cnt_reg, OFF_TPA, 8'd4))   hdr_reg.tpa   <= {hdr_reg.tpa[23:0], arp_rx_data};
    end
  end

  // Pending reply request; a new set beats a same-cycle ack and overwrites the target
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      arp_reply_req <= 1'b0;
      arp_reply_ip  <= '0;
      arp_reply_mac <= '0;
    end else if (reply_set) begin
      arp_reply_req <= 1'b1;
      arp_reply_ip  <= hdr_reg.spa;
      arp_reply_mac <= hdr_reg.sha;
    end else if (arp_reply_ack) begin
      arp_reply_req <= 1'b0;
    end
  end

  arp_cache #(
    .CACHE_DEPTH (CACHE_DEPTH),
    .AGE_W       (AGE_W),
    .MAX_AGE     (MAX_AGE)
  ) u_cache (
    .clk         (clk),
    .rst_n       (rst_n),
    .age_tick    (age_tick),
    .match_ip    (hdr_reg.spa),
    .match_hit   (spa_hit),
    .match_idx   (spa_idx),
    .refresh_en  (refresh_en),
    .refresh_idx (hit_idx_reg),
    .insert_en   (insert_en),
    .wr_ip       (hdr_reg.spa),
    .wr_mac      (hdr_reg.sha),
    .lookup_req  (lookup_req),
    .lookup_ip   (lookup_ip),
    .lookup_ack  (lookup_ack),
    .lookup_hit  (lookup_hit),
    .lookup_mac  (lookup_mac)
  );

endmodule

// File: tb/tb_arp_rx_cache.sv
// Self-checking bench for arp_rx_cache: directed scenarios followed by
// randomized frames, checked against a behavioural cache/reply model.
module tb_arp_rx_cache;
  localparam int DEPTH = 4;
  localparam int MAXA  = 200;
  localparam logic [31:0] LIP  = 32'hC0A8000A;
  localparam logic [47:0] LMAC = 48'h02005E10000A;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        arp_rx_req, arp_rx_valid, arp_rx_last, arp_rx_end;
  logic [7:0]  arp_rx_data;
  logic        arp_reply_req, arp_reply_ack, arp_found, age_tick;
  logic [31:0] arp_reply_ip, lookup_ip;
  logic [47:0] arp_reply_mac, lookup_mac;
  logic        lookup_req, lookup_ack, lookup_hit;

  always #5 clk = ~clk;

  arp_rx_cache #(.CACHE_DEPTH(DEPTH), .AGE_W(8), .MAX_AGE(8'd200)) dut (
    .clk(clk), .rst_n(rst_n), .local_ip_addr(LIP), .local_mac_addr(LMAC),
    .arp_rx_req(arp_rx_req), .arp_rx_valid(arp_rx_valid), .arp_rx_data(arp_rx_data),
    .arp_rx_last(arp_rx_last), .arp_rx_end(arp_rx_end), .arp_reply_req(arp_reply_req),
    .arp_reply_ack(arp_reply_ack), .arp_reply_ip(arp_reply_ip), .arp_reply_mac(arp_reply_mac),
    .arp_found(arp_found), .age_tick(age_tick), .lookup_req(lookup_req), .lookup_ip(lookup_ip),
    .lookup_ack(lookup_ack), .lookup_hit(lookup_hit), .lookup_mac(lookup_mac)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  bit          m_valid [DEPTH];
  logic [31:0] m_ip    [DEPTH];
  logic [47:0] m_mac   [DEPTH];
  int          m_age   [DEPTH];
  int          m_ptr;
  bit          m_pend;
  logic [31:0] m_rip;
  logic [47:0] m_rmac;

  // Current frame fields
  logic [15:0] f_htype, f_ptype, f_oper;
  logic [7:0]  f_hlen, f_plen;
  logic [47:0] f_sha, f_tha;
  logic [31:0] f_spa, f_tpa;
  int          f_len;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model_clear();
    for (int i = 0; i < DEPTH; i++) m_valid[i] = 0;
    m_ptr = 0; m_pend = 0; m_rip = '0; m_rmac = '0;
  endfunction

  task automatic model_find(input logic [31:0] ip, output bit hit, output int idx,
                            output logic [47:0] mac);
    hit = 0; idx = -1; mac = '0;
    for (int i = 0; i < DEPTH; i++)
      if (!hit && m_valid[i] && m_ip[i] == ip) begin hit = 1; idx = i; mac = m_mac[i]; end
  endtask

  function automatic void model_tick();
    for (int i = 0; i < DEPTH; i++)
      if (m_valid[i]) begin
        m_age[i]--;
        if (m_age[i] == 0) m_valid[i] = 0;
      end
  endfunction

  // Apply the effects of one received frame; returns whether arp_found should pulse
  task automatic model_frame(input bit tick_at, input bit ack_at, output bit exp_found);
    bit ok, hit; int hidx, free, tgt; logic [47:0] dmac;
    ok = (f_len >= 28) && f_htype == 16'h0001 && f_ptype == 16'h0800 && f_hlen == 8'd6 &&
         f_plen == 8'd4 && (f_oper == 16'd1 || f_oper == 16'd2) && f_spa != 0 && !f_sha[40];
    model_find(f_spa, hit, hidx, dmac);
    free = -1;
    for (int i = DEPTH - 1; i >= 0; i--) if (!m_valid[i]) free = i;
    if (tick_at) model_tick();
    tgt = -1;
    if (ok && hit) tgt = hidx;
    else if (ok && f_tpa == LIP) begin
      if (free >= 0) tgt = free;
      else begin tgt = m_ptr; m_ptr = (m_ptr + 1) % DEPTH; end
    end
    if (tgt >= 0) begin
      m_valid[tgt] = 1; m_ip[tgt] = f_spa; m_mac[tgt] = f_sha; m_age[tgt] = MAXA;
    end
    if (ok && f_oper == 16'd1 && f_tpa == LIP) begin
      m_pend = 1; m_rip = f_spa; m_rmac = f_sha;
    end else if (ack_at) m_pend = 0;
    exp_found = ok && f_oper == 16'd2 && f_tpa == LIP && f_tha == LMAC;
  endtask

  task automatic set_frame(input logic [31:0] spa, input logic [47:0] sha, input logic [15:0] oper,
                           input logic [31:0] tpa, input logic [47:0] tha, input int len);
    f_htype = 16'h0001; f_ptype = 16'h0800; f_hlen = 8'd6; f_plen = 8'd4;
    f_oper = oper; f_sha = sha; f_spa = spa; f_tha = tha; f_tpa = tpa; f_len = len;
  endtask

  function automatic logic [7:0] frame_byte(input int i);
    if (i < 2)  return f_htype[8*(1-i) +: 8];
    if (i < 4)  return f_ptype[8*(3-i) +: 8];
    if (i == 4) return f_hlen;
    if (i == 5) return f_plen;
    if (i < 8)  return f_oper[8*(7-i) +: 8];
    if (i < 14) return f_sha[8*(13-i) +: 8];
    if (i < 18) return f_spa[8*(17-i) +: 8];
    if (i < 24) return f_tha[8*(23-i) +: 8];
    if (i < 28) return f_tpa[8*(27-i) +: 8];
    return 8'($urandom);
  endfunction

  task automatic check_reply(input string tag);
    chk({tag, ".reply_req"}, arp_reply_req, m_pend);
    chk({tag, ".reply_ip"},  arp_reply_ip,  m_rip);
    chk({tag, ".reply_mac"}, arp_reply_mac, m_rmac);
  endtask

  // Stream the current frame; optional ack/lookup/age_tick land on the UPDATE-write edge
  task automatic send_frame(input string tag, input bit ack_at, input bit lk_at,
                            input bit tick_at, input bit gaps);
    logic [3:0] endp, exp_endp; int fc; bit ef, lh; int li; logic [47:0] lm;
    @(negedge clk); arp_rx_req = 1;
    @(negedge clk); arp_rx_req = 0;
    for (int i = 0; i < f_len; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        arp_rx_valid = 0; arp_rx_last = 0; arp_rx_req = 1;
        @(negedge clk); arp_rx_req = 0;
      end
      arp_rx_valid = 1; arp_rx_data = frame_byte(i); arp_rx_last = (i == f_len - 1);
      @(negedge clk);
    end
    arp_rx_valid = 0; arp_rx_last = 0; arp_rx_data = 0;
    endp[0] = arp_rx_end; fc = int'(arp_found);
    @(negedge clk);
    endp[1] = arp_rx_end; fc += int'(arp_found);
    model_find(f_spa, lh, li, lm);
    if (ack_at) arp_reply_ack = 1;
    if (lk_at) begin lookup_req = 1; lookup_ip = f_spa; end
    if (tick_at) age_tick = 1;
    @(negedge clk);
    endp[2] = arp_rx_end; fc += int'(arp_found);
    arp_reply_ack = 0; lookup_req = 0; age_tick = 0;
    model_frame(tick_at, ack_at, ef);
    if (lk_at) begin
      chk({tag, ".lk_at_write.ack"}, lookup_ack, 1'b1);
      chk({tag, ".lk_at_write.hit"}, lookup_hit, lh);
      chk({tag, ".lk_at_write.mac"}, lookup_mac, lm);
    end
    @(negedge clk);
    endp[3] = arp_rx_end; fc += int'(arp_found);
    exp_endp = (f_len >= 28) ? 4'b0100 : 4'b0001;
    chk({tag, ".rx_end_timing"}, endp, exp_endp);
    chk({tag, ".found_count"}, fc, ef ? 1 : 0);
    check_reply(tag);
  endtask

  task automatic do_lookup(input string tag, input logic [31:0] ip);
    bit eh; int ei; logic [47:0] em;
    model_find(ip, eh, ei, em);
    @(negedge clk); lookup_req = 1; lookup_ip = ip;
    @(negedge clk); lookup_req = 0; lookup_ip = $urandom;
    chk({tag, ".ack"}, lookup_ack, 1'b1);
    chk({tag, ".hit"}, lookup_hit, eh);
    chk({tag, ".mac"}, lookup_mac, em);
    @(negedge clk);
    chk({tag, ".ack_pulse"}, lookup_ack, 1'b0);
  endtask

  task automatic do_ack(input string tag);
    @(negedge clk); arp_reply_ack = 1;
    @(negedge clk); arp_reply_ack = 0; m_pend = 0;
    chk({tag, ".req_cleared"}, arp_reply_req, 1'b0);
  endtask

  task automatic do_ticks(input int n);
    for (int k = 0; k < n; k++) begin @(negedge clk); age_tick = 1; model_tick(); end
    @(negedge clk); age_tick = 0;
  endtask

  task automatic do_reset();
    @(negedge clk); rst_n = 0;
    repeat (2) @(negedge clk);
    rst_n = 1; model_clear();
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, ".rx_end"}, arp_rx_end, 1'b0);
    chk({tag, ".found"}, arp_found, 1'b0);
    chk({tag, ".lookup"}, {lookup_ack, lookup_hit, lookup_mac}, 50'd0);
    chk({tag, ".reply"}, {arp_reply_req, arp_reply_ip, arp_reply_mac}, 81'd0);
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] t;
    int r;
    rst_n = 0; arp_rx_req = 0; arp_rx_valid = 0; arp_rx_data = 0; arp_rx_last = 0;
    arp_reply_ack = 0; age_tick = 0; lookup_req = 0; lookup_ip = 0;
    model_clear();
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rst_n = 1;
    @(negedge clk);
    check_idle_outputs("after_reset");
    do_lookup("reset_empty", 32'hC0A80002);

    // Basic request with 18 padding bytes
    set_frame(32'hC0A80002, 48'h000A35010203, 16'd1, LIP, 48'h0, 46);
    send_frame("req_basic", 0, 0, 0, 0);
    chk("req_basic.ip_const", arp_reply_ip, 32'hC0A80002);
    chk("req_basic.mac_const", arp_reply_mac, 48'h000A35010203);
    do_lookup("req_basic.lookup", 32'hC0A80002);
    do_ack("req_basic");

    // Bad HTYPE and a frame ending at byte 20
    set_frame(32'hC0A80033, 48'h000A35AABBCC, 16'd1, LIP, 48'h0, 28);
    f_htype = 16'h0006;
    send_frame("bad_htype", 0, 0, 0, 0);
    do_lookup("bad_htype.lookup", 32'hC0A80033);
    set_frame(32'hC0A80034, 48'h000A35AABBCD, 16'd1, LIP, 48'h0, 21);
    send_frame("short21", 0, 0, 0, 0);
    do_lookup("short21.lookup", 32'hC0A80034);

    // Five inserts into four entries, then a sixth to show the pointer moved on
    do_reset();
    for (int k = 0; k < 5; k++) begin
      set_frame(32'h0A000101 + k, 48'h000A35000000 + k, 16'd1, LIP, 48'h0, 28);
      send_frame("fill", 0, 0, 0, 0);
    end
    for (int k = 0; k < 5; k++) do_lookup("fill.lookup", 32'h0A000101 + k);
    set_frame(32'h0A000106, 48'h000A35000006, 16'd1, LIP, 48'h0, 28);
    send_frame("fill6", 0, 0, 0, 0);
    do_lookup("fill6.old_entry1", 32'h0A000102);
    do_lookup("fill6.new", 32'h0A000106);
    do_ack("fill");

    // Aging to expiry
    do_reset();
    set_frame(32'h0A0000AA, 48'h000A350000AA, 16'd1, LIP, 48'h0, 30);
    send_frame("age_ins", 0, 0, 0, 0);
    do_ticks(MAXA - 1);
    do_lookup("age_199", 32'h0A0000AA);
    do_ticks(1);
    do_lookup("age_200", 32'h0A0000AA);

    // Reply addressed to us, then a request pending when a new one arrives with an ack
    set_frame(32'hC0A80002, 48'h000A35010203, 16'd1, LIP, 48'h0, 28);
    send_frame("pre_found", 0, 0, 0, 0);
    set_frame(32'hC0A80002, 48'h000A35998877, 16'd2, LIP, LMAC, 40);
    send_frame("found", 0, 0, 0, 0);
    do_lookup("found.refresh", 32'hC0A80002);
    set_frame(32'hC0A80077, 48'h000A35111111, 16'd1, LIP, 48'h0, 28);
    send_frame("ack_same", 1, 0, 0, 0);
    chk("ack_same.ip_const", arp_reply_ip, 32'hC0A80077);

    // Reset in the middle of RECV
    set_frame(32'hC0A80055, 48'h000A35555555, 16'd1, LIP, 48'h0, 28);
    @(negedge clk); arp_rx_req = 1;
    @(negedge clk); arp_rx_req = 0;
    for (int i = 0; i < 12; i++) begin
      arp_rx_valid = 1; arp_rx_data = frame_byte(i); arp_rx_last = 0;
      @(negedge clk);
    end
    rst_n = 0;
    #1;
    check_idle_outputs("mid_reset");
    @(negedge clk); arp_rx_valid = 0;
    @(negedge clk); rst_n = 1; model_clear();
    repeat (4) begin
      @(negedge clk);
      chk("mid_reset.no_end", arp_rx_end, 1'b0);
    end
    do_lookup("mid_reset.empty", 32'hC0A80002);
    do_lookup("mid_reset.empty2", 32'hC0A80077);
    set_frame(32'hC0A80055, 48'h000A35555555, 16'd1, LIP, 48'h0, 28);
    send_frame("post_reset", 0, 0, 0, 0);

    // Randomized frames
    for (int it = 0; it < 80; it++) begin
      t = {$urandom, $urandom};
      set_frame(32'h0A000001 + $urandom_range(0, 5), t[47:0] & ~(48'h1 << 40),
                16'($urandom_range(1, 2)), ($urandom_range(0, 9) < 7) ? LIP : 32'hC0A80063,
                ($urandom_range(0, 1) == 1) ? LMAC : {t[63:48], t[31:0]}, 28 + $urandom_range(0, 6));
      r = $urandom_range(0, 11);
      case (r)
        0: f_htype = 16'h0006;
        1: f_ptype = 16'h86DD;
        2: f_hlen = 8'd8;
        3: f_plen = 8'd16;
        4: f_oper = 16'd3;
        5: f_spa = 32'd0;
        6: f_sha[40] = 1'b1;
        7: f_len = $urandom_range(1, 27);
        default: ;
      endcase
      send_frame("rand", $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1);
      if (m_pend && $urandom_range(0, 1) == 1) do_ack("rand");
      do_lookup("rand.lookup", 32'h0A000001 + $urandom_range(0, 5));
      if ($urandom_range(0, 4) == 0) do_ticks($urandom_range(1, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/arp_rx_cache.md
# arp_rx_cache

ARP receiver with a parametrised cache of resolved IP-to-MAC entries. It parses ARP payload bytes streamed from the MAC RX path, validates every fixed header field, and raises a reply request toward the ARP TX path. It learns and ages sender bindings and answers IP-to-MAC lookups from the IP/UDP TX path. It replaces the fixed-offset, single-entry ARP receiver.

## Interface
- CACHE_DEPTH, 4: number of cache entries (power of two, 2..16).
- AGE_W, 8: width of each entry's age counter.
- MAX_AGE, 8'd200: age value loaded on insert or refresh, in `age_tick` units.
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- local_ip_addr  in  32  own IPv4 address.
- local_mac_addr  in  48  own MAC address.
- arp_rx_req  in  1  one-cycle pulse marking the start of an ARP payload.
- arp_rx_valid  in  1  `arp_rx_data` holds a payload byte.
- arp_rx_data  in  8  payload byte; byte 0 is the first HTYPE byte.
- arp_rx_last  in  1  qualifies the final valid byte, padding included.
- arp_rx_end  out  1  one-cycle pulse when frame processing finishes.
- arp_reply_req  out  1  held high until acknowledged.
- arp_reply_ack  in  1  one-cycle acknowledge from the ARP TX path.
- arp_reply_ip  out  32  requester IP to answer.
- arp_reply_mac  out  48  requester MAC to answer.
- arp_found  out  1  one-cycle pulse when a valid reply addressed to us is learned.
- age_tick  in  1  aging strobe.
- lookup_req  in  1  one-cycle lookup strobe.
- lookup_ip  in  32  IP to resolve; sampled on `lookup_req`.
- lookup_ack  out  1  one-cycle pulse, exactly 1 cycle after `lookup_req`.
- lookup_hit  out  1  qualified by `lookup_ack`.
- lookup_mac  out  48  qualified by `lookup_ack` and `lookup_hit`; 0 on a miss.

## Operation
- States: IDLE, RECV, CHECK, UPDATE, DONE.
- IDLE→RECV on `arp_rx_req`; the byte counter clears. `arp_rx_req` is ignored outside IDLE.
- RECV: the 8-bit counter (saturating at 255) advances on each valid byte. Fields are captured at byte offsets:
  - 0-1 HTYPE, 2-3 PTYPE, 4 HLEN, 5 PLEN, 6-7 OPER
  - 8-13 SHA, 14-17 SPA, 18-23 THA, 24-27 TPA.
- RECV exit on the `arp_rx_last` byte:
  - if fewer than 28 bytes were received, go to DONE with the frame dropped;
  - otherwise go to CHECK. Bytes beyond offset 27 are ignored.
- CHECK, the frame is valid when:
  - HTYPE=0x0001, PTYPE=0x0800, HLEN=6, PLEN=4;
  - OPER is 1 or 2;
  - SPA≠0 and SHA is not broadcast or multicast (SHA[40]=0).
  - CHECK also evaluates an all-entry match of SPA against valid cache entries.
- UPDATE:
  - if valid and SPA hits: overwrite the MAC and reload age to MAX_AGE.
  - if valid, SPA misses, and TPA==local_ip_addr: insert into the lowest-index invalid entry; if none is free, replace the entry at the round-robin pointer and then advance the pointer (wraps at CACHE_DEPTH-1).
  - otherwise: no write.
- DONE: pulse `arp_rx_end`, then return to IDLE.
  - Request (OPER=1) with TPA==local_ip_addr: set `arp_reply_req` and latch SPA/SHA into `arp_reply_ip`/`arp_reply_mac`.
  - Reply (OPER=2) with TPA==local_ip_addr and THA==local_mac_addr: pulse `arp_found`.
- Aging: each `age_tick` decrements every valid entry. An entry whose age reaches 0 is invalidated in the same cycle.
- A lookup compares `lookup_ip` against all valid entries; on multiple hits the lowest index wins.

## Timing
- Reset values: all outputs 0; all entries invalid; round-robin pointer 0; state IDLE.
- `arp_rx_end` asserts 3 cycles after the `arp_rx_last` beat for an accepted frame, and 1 cycle after it for a dropped frame.
- `arp_reply_req`:
  - cleared on `arp_reply_ack`;
  - a set and an ack in the same cycle leave it set;
  - a new qualifying request while a reply is pending overwrites the reply IP/MAC and keeps the request high.
- Lookup in the same cycle as an UPDATE write returns the pre-write contents.
- `age_tick` in the same cycle as an UPDATE write to the same entry: the write wins (age=MAX_AGE, entry valid).
- A reset asserted mid-frame returns to IDLE immediately; no partial cache write occurs.

## Structure
- Package `arp_pkg`:
  - ARP_REQUEST_CODE, ARP_REPLY_CODE, HTYPE_ETH, PTYPE_IPV4;
  - field offset constants;
  - state encoding.
- Sub-module `arp_cache`: entry storage, age counters, insert/refresh logic, round-robin pointer, SPA match, and the registered lookup port.
- Top level: byte parser, FSM, reply and found logic.

## Test plan
- Request from 192.168.0.2 / 00:0a:35:01:02:03 for local 192.168.0.10, with 18 padding bytes:
  - `arp_reply_req`=1 with those IP/MAC values;
  - `arp_rx_end` 3 cycles after last;
  - a lookup of 192.168.0.2 → hit, MAC 00:0a:35:01:02:03.
- Frame with HTYPE=0x0006, or a frame ending at byte 20 → `arp_rx_end` pulses, no reply, no cache change.
- Five distinct valid requests into a 4-entry cache → entries 0-3 filled, the fifth overwrites entry 0, pointer=1.
- Insert, then MAX_AGE `age_tick` pulses → the next lookup misses, and `lookup_mac`=0.
- Reply with THA=local MAC and TPA=local IP → `arp_found` pulses once; SPA is refreshed in the cache.
- `arp_reply_ack` in the same cycle as a new set → `arp_reply_req` stays 1 with the new IP; reset asserted mid-RECV → all outputs 0 and cache empty.
